// File: rtl/instr_encoder_loader.sv
// Packs MIPS instruction fields into 32-bit words and streams them into imem.
// Optional feature: define ENC_CHECKSUM_EN for a running XOR checksum port.
module instr_encoder_loader #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_opcode,
  input  logic [5:0]    in_funct,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_illegal,
  output logic          err_overflow,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic [AW:0]   word_count
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_ill_q, err_ill_d;
  logic          err_ovf_q, err_ovf_d;

  logic          legal;
  logic [31:0]   enc_word;
  logic          xfer;

  // Field packer: format chosen by opcode class; unknown opcodes flagged illegal.
  always_comb begin
    legal    = 1'b1;
    enc_word = 32'h0;
    unique case (in_opcode)
      OP_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      OP_J, OP_JAL: enc_word = {in_opcode, in_target};
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
      OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
        enc_word = {in_opcode, in_rs, in_rt, in_imm};
      default: legal = 1'b0;
    endcase
  end

  // ready_q mirrors (state==ACTIVE && count<DEPTH) for the current cycle.
  assign xfer = in_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ACTIVE;
          count_d   = '0;
          base_d    = base_addr;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = base_q + count_q[AW-1:0];
            wdata_d = enc_word;
            count_d = count_q + CW'(1);
          end else begin
            err_ill_d = 1'b1;
          end
          if (in_last) state_d = S_FLUSH;
        end else if (in_valid && (count_q == DEPTH_C)) begin
          state_d   = S_DONE;
          err_ovf_d = 1'b1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_ACTIVE) && (count_d < DEPTH_C);
    busy_d  = (state_d == S_ACTIVE) || (state_d == S_FLUSH);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running XOR of every word actually written this session.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) csum_d = '0;
    else if (state_q == S_ACTIVE && xfer && legal)         csum_d = csum_q ^ enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: default, wrap (AW=4/DEPTH=16) and
// overflow (DEPTH=2) instances share field inputs but have separate start pulses.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_w, start_o;
  logic [9:0]  base_addr;
  logic        in_valid, in_last;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        ready, we, busy, done, eill, eovf;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [10:0] wcnt;

  logic        ready_w, we_w, busy_w, done_w, eill_w, eovf_w;
  logic [3:0]  addr_w;
  logic [31:0] wdata_w;
  logic [4:0]  wcnt_w;

  logic        ready_o, we_o, busy_o, done_o, eill_o, eovf_o;
  logic [9:0]  addr_o;
  logic [31:0] wdata_o;
  logic [10:0] wcnt_o;

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum, csum_w, csum_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.AW(10), .DEPTH(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(ready), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(we), .imem_addr(addr), .imem_wdata(wdata), .busy(busy), .done(done),
    .err_illegal(eill), .err_overflow(eovf),
`ifdef ENC_CHECKSUM_EN
    .checksum(csum),
`endif
    .word_count(wcnt)
  );

  instr_encoder_loader #(.AW(4), .DEPTH(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .base_addr(base_addr[3:0]),
    .in_valid(in_valid), .in_ready(ready_w), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(we_w), .imem_addr(addr_w), .imem_wdata(wdata_w), .busy(busy_w), .done(done_w),
    .err_illegal(eill_w), .err_overflow(eovf_w),
`ifdef ENC_CHECKSUM_EN
    .checksum(csum_w),
`endif
    .word_count(wcnt_w)
  );

  instr_encoder_loader #(.AW(10), .DEPTH(2)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start_o), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(ready_o), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(we_o), .imem_addr(addr_o), .imem_wdata(wdata_o), .busy(busy_o), .done(done_o),
    .err_illegal(eill_o), .err_overflow(eovf_o),
`ifdef ENC_CHECKSUM_EN
    .checksum(csum_o),
`endif
    .word_count(wcnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fields();
    in_opcode = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0;
  endtask

  task automatic put_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] fn, input logic last);
    clr_fields();
    in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn;
    in_valid = 1'b1; in_last = last;
  endtask

  task automatic put_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic last);
    clr_fields();
    in_opcode = op; in_rs = rs; in_rt = rt; in_imm = imm;
    in_valid = 1'b1; in_last = last;
  endtask

  task automatic put_j(input logic [5:0] op, input logic [25:0] tgt, input logic last);
    clr_fields();
    in_opcode = op; in_target = tgt;
    in_valid = 1'b1; in_last = last;
  endtask

  task automatic idle_in();
    clr_fields();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"},    32'(we),    32'h0);
    chk({tag, ".addr"},  32'(addr),  32'h0);
    chk({tag, ".wdata"}, wdata,      32'h0);
    chk({tag, ".rdy"},   32'(ready), 32'h0);
    chk({tag, ".busy"},  32'(busy),  32'h0);
    chk({tag, ".done"},  32'(done),  32'h0);
    chk({tag, ".eill"},  32'(eill),  32'h0);
    chk({tag, ".eovf"},  32'(eovf),  32'h0);
    chk({tag, ".cnt"},   32'(wcnt),  32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0; start_o = 1'b0;
    base_addr = '0;
    idle_in();
    tick(); tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // Single ADDI with last
    base_addr = 10'h010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("addi.rdy", 32'(ready), 32'h1);
    chk("addi.busy", 32'(busy), 32'h1);
    put_i(6'h08, 5'd1, 5'd2, 16'h0005, 1'b1);
    tick();
    idle_in();
    chk("addi.we", 32'(we), 32'h1);
    chk("addi.addr", 32'(addr), 32'h010);
    chk("addi.wdata", wdata, 32'h20220005);
    chk("addi.cnt", 32'(wcnt), 32'h1);
    chk("addi.flush_done", 32'(done), 32'h0);
    chk("addi.flush_rdy", 32'(ready), 32'h0);
    tick();
    chk("addi.we_off", 32'(we), 32'h0);
    chk("addi.done", 32'(done), 32'h1);
    chk("addi.busy_off", 32'(busy), 32'h0);
    tick();
    chk("addi.done_hold", 32'(done), 32'h1);

    // Three back-to-back R-type adds, restarted from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rt.done_clr", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      put_r(5'd1, 5'd2, 5'd3, 6'h20, (i == 2));
      tick();
      chk($sformatf("rt%0d.we", i), 32'(we), 32'h1);
      chk($sformatf("rt%0d.addr", i), 32'(addr), 32'h010 + 32'(i));
      chk($sformatf("rt%0d.wdata", i), wdata, 32'h00221820);
    end
    idle_in();
    tick();
    chk("rt.we_off", 32'(we), 32'h0);
    chk("rt.done", 32'(done), 32'h1);
    chk("rt.cnt", 32'(wcnt), 32'h3);

    // Illegal opcode mid-stream, then J
    base_addr = 10'h020; start = 1'b1;
    tick();
    start = 1'b0;
    put_i(6'h0D, 5'd4, 5'd5, 16'hBEEF, 1'b0);
    tick();
    chk("ill.ori_wdata", wdata, 32'h3485BEEF);
    chk("ill.ori_addr", 32'(addr), 32'h020);
    put_i(6'h3F, 5'd1, 5'd1, 16'h1234, 1'b0);
    tick();
    chk("ill.we", 32'(we), 32'h0);
    chk("ill.flag", 32'(eill), 32'h1);
    chk("ill.cnt", 32'(wcnt), 32'h1);
    put_j(6'h02, 26'h0000100, 1'b1);
    tick();
    idle_in();
    chk("ill.j_we", 32'(we), 32'h1);
    chk("ill.j_addr", 32'(addr), 32'h021);
    chk("ill.j_wdata", wdata, 32'h08000100);
    tick();
    chk("ill.done", 32'(done), 32'h1);
    chk("ill.flag_hold", 32'(eill), 32'h1);

    // Restart clears flags; illegal in_last still flushes
    base_addr = 10'h3FF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs.eill_clr", 32'(eill), 32'h0);
    chk("rs.cnt_clr", 32'(wcnt), 32'h0);
    put_i(6'h3F, 5'd0, 5'd0, 16'h0, 1'b1);
    tick();
    idle_in();
    chk("ilast.we", 32'(we), 32'h0);
    chk("ilast.busy", 32'(busy), 32'h1);
    tick();
    chk("ilast.done", 32'(done), 32'h1);
    chk("ilast.eill", 32'(eill), 32'h1);

    // Start ignored while ACTIVE; 10-bit address wrap on the default instance
    start = 1'b1;
    tick();
    base_addr = 10'h100;
    put_j(6'h03, 26'h3FFFFFF, 1'b0);
    tick();
    chk("jal.addr", 32'(addr), 32'h3FF);
    chk("jal.wdata", wdata, 32'h0FFFFFFF);
    put_i(6'h23, 5'd29, 5'd8, 16'hFFFC, 1'b0);
    tick();
    start = 1'b0;
    chk("lw.addr_wrap", 32'(addr), 32'h000);
    chk("lw.wdata", wdata, 32'h8FA8FFFC);
    chk("ign.cnt", 32'(wcnt), 32'h2);

    // Reset with a transfer pending
    put_r(5'd7, 5'd7, 5'd7, 6'h25, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mrst");
    tick();
    chk("mrst.we", 32'(we), 32'h0);
    idle_in();
    rst_n = 1'b1;
    tick();

    // Wrap on AW=4, DEPTH=16
    base_addr = 10'h00E; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put_i(6'h08, 5'd0, 5'd1, 16'(i), (i == 2));
      tick();
      chk($sformatf("wrap%0d.we", i), 32'(we_w), 32'h1);
      chk($sformatf("wrap%0d.addr", i), 32'(addr_w), (32'hE + 32'(i)) & 32'hF);
      chk($sformatf("wrap%0d.wdata", i), wdata_w, 32'h20010000 | 32'(i));
    end
    idle_in();
    tick();
    chk("wrap.done", 32'(done_w), 32'h1);
    chk("wrap.eovf", 32'(eovf_w), 32'h0);
    chk("wrap.cnt", 32'(wcnt_w), 32'h3);
    chk("wrap.dflt_idle", 32'(we), 32'h0);

    // Overflow on DEPTH=2
    base_addr = 10'h000; start_o = 1'b1;
    tick();
    start_o = 1'b0;
    put_r(5'd1, 5'd2, 5'd3, 6'h20, 1'b0);
    tick();
    chk("ovf0.we", 32'(we_o), 32'h1);
    chk("ovf0.addr", 32'(addr_o), 32'h0);
    chk("ovf0.rdy", 32'(ready_o), 32'h1);
    tick();
    chk("ovf1.we", 32'(we_o), 32'h1);
    chk("ovf1.addr", 32'(addr_o), 32'h1);
    chk("ovf1.rdy", 32'(ready_o), 32'h0);
    chk("ovf1.eovf", 32'(eovf_o), 32'h0);
    in_last = 1'b1;
    tick();
    idle_in();
    chk("ovf2.we", 32'(we_o), 32'h0);
    chk("ovf2.eovf", 32'(eovf_o), 32'h1);
    chk("ovf2.done", 32'(done_o), 32'h1);
    chk("ovf2.cnt", 32'(wcnt_o), 32'h2);
    chk("ovf2.rdy", 32'(ready_o), 32'h0);
    tick();
    chk("ovf.hold", 32'(eovf_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
